// File: rtl/tx_arb_pkg.sv
// tx_cmd_arbiter shared types: FSM state enum, idle byte default and frame byte-index constants.
// Optional TX_ARB_TIMEOUT_EN adds the ABORT state used by the watchdog.
package tx_arb_pkg;

   localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;
   localparam int BYTE_W = 8;
   localparam int IDX_W = 2;
   localparam logic [IDX_W-1:0] FIRST_BYTE = '0;

`ifdef TX_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE,
      S_ABORT
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_t;
`endif

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner search over req & mask.
// Ports: req, mask (per channel), last_grant -> valid, index. RR_EN=1 starts after last_grant.
module arb_pick #(
   parameter int NUM_CH = 2,
   parameter int RR_EN = 0
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] mask,
   input  logic [2:0]        last_grant,
   output logic              valid,
   output logic [2:0]        index
);

   logic [NUM_CH-1:0] elig;

   assign elig = req & mask;

   // Loops run from the lowest priority to the highest so the final
   // assignment made is the winner.
   always_comb begin
      valid = |elig;
      index = '0;
      if (RR_EN != 0) begin
         for (int k = NUM_CH; k >= 1; k--) begin
            if (elig[(int'(last_grant) + k) % NUM_CH])
               index = 3'((int'(last_grant) + k) % NUM_CH);
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig[i])
               index = 3'(i);
         end
      end
   end

endmodule

// File: rtl/tx_cmd_arbiter.sv
// tx_cmd_arbiter: grants one command source at a time and feeds its frame bytewise to a UART.
// Ports: clock, reset (sync, active-low), ch_req/ch_frame/ch_mask in, ch_ack out,
// tx_bits/tx_done UART side, busy, grant_id, err. Macro TX_ARB_TIMEOUT_EN adds a watchdog abort.
module tx_cmd_arbiter
   import tx_arb_pkg::*;
#(
   parameter int          NUM_CH      = 2,
   parameter int          FRAME_LEN   = 3,
   parameter int          RR_EN       = 0,
   parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEF,
   parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_CH-1:0]              ch_req,
   input  logic [NUM_CH*FRAME_LEN*8-1:0]  ch_frame,
   input  logic [NUM_CH-1:0]              ch_mask,
   output logic [NUM_CH-1:0]              ch_ack,
   output logic [7:0]                     tx_bits,
   input  logic                           tx_done,
   output logic                           busy,
   output logic [2:0]                     grant_id,
   output logic                           err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] nxt_idx;
   logic [2:0]       last_grant;
   logic [7:0]       frame_q [FRAME_LEN];
   logic             pick_valid;
   logic [2:0]       pick_idx;

   assign nxt_idx = idx + IDX_W'(1);

   arb_pick #(
      .NUM_CH (NUM_CH),
      .RR_EN  (RR_EN)
   ) u_pick (
      .req        (ch_req),
      .mask       (ch_mask),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

`ifdef TX_ARB_TIMEOUT_EN
   logic [15:0] wd;
`else
   logic timeout_unused;
   assign timeout_unused = ^TIMEOUT_CYC;
   assign err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= S_IDLE;
         idx        <= FIRST_BYTE;
         busy       <= 1'b0;
         ch_ack     <= '0;
         grant_id   <= '0;
         tx_bits    <= IDLE_BYTE;
         last_grant <= 3'(NUM_CH - 1);
         for (int b = 0; b < FRAME_LEN; b++)
            frame_q[b] <= '0;
`ifdef TX_ARB_TIMEOUT_EN
         err        <= 1'b0;
         wd         <= '0;
`endif
      end else begin
         ch_ack <= '0;
`ifdef TX_ARB_TIMEOUT_EN
         err    <= 1'b0;
`endif
         unique case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  // Snapshot the whole frame so later ch_frame edits are harmless.
                  for (int b = 0; b < FRAME_LEN; b++)
                     frame_q[b] <= ch_frame[(int'(pick_idx) * FRAME_LEN + b) * BYTE_W +: BYTE_W];
                  tx_bits    <= ch_frame[int'(pick_idx) * FRAME_LEN * BYTE_W +: BYTE_W];
                  grant_id   <= pick_idx;
                  last_grant <= pick_idx;
                  idx        <= FIRST_BYTE;
                  busy       <= 1'b1;
                  state      <= S_SEND;
`ifdef TX_ARB_TIMEOUT_EN
                  wd         <= '0;
`endif
               end
            end
            S_SEND: begin
               if (tx_done) begin
`ifdef TX_ARB_TIMEOUT_EN
                  wd <= '0;
`endif
                  if (idx == LAST_IDX) begin
                     tx_bits <= IDLE_BYTE;
                     state   <= S_DONE;
                     for (int i = 0; i < NUM_CH; i++)
                        ch_ack[i] <= (grant_id == 3'(i));
                  end else begin
                     idx     <= nxt_idx;
                     tx_bits <= frame_q[nxt_idx];
                  end
               end
`ifdef TX_ARB_TIMEOUT_EN
               else if (wd == TIMEOUT_CYC - 16'd1) begin
                  tx_bits <= IDLE_BYTE;
                  err     <= 1'b1;
                  state   <= S_ABORT;
               end else begin
                  wd <= wd + 16'd1;
               end
`endif
            end
            S_DONE: begin
               busy  <= 1'b0;
               idx   <= FIRST_BYTE;
               state <= S_IDLE;
            end
`ifdef TX_ARB_TIMEOUT_EN
            S_ABORT: begin
               busy  <= 1'b0;
               idx   <= FIRST_BYTE;
               wd    <= '0;
               state <= S_IDLE;
            end
`endif
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_cmd_arbiter.sv
// Bench for tx_cmd_arbiter: fixed-priority and round-robin instances, vector table plus corner sequences.
// The watchdog sequence is compiled in only with TX_ARB_TIMEOUT_EN.
module tb_tx_cmd_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   logic [1:0]  req, mask, ack;
   logic [47:0] frame;
   logic [7:0]  bits;
   logic        done, busy, err;
   logic [2:0]  gid;

   logic [1:0]  r_req, r_mask, r_ack;
   logic [47:0] r_frame;
   logic [7:0]  r_bits;
   logic        r_done, r_busy, r_err;
   logic [2:0]  r_gid;

   tx_cmd_arbiter #(
      .NUM_CH(2), .FRAME_LEN(3), .RR_EN(0),
      .IDLE_BYTE(8'h00), .TIMEOUT_CYC(16'd16)
   ) dut (
      .clock(clock), .reset(reset), .ch_req(req), .ch_frame(frame),
      .ch_mask(mask), .ch_ack(ack), .tx_bits(bits), .tx_done(done),
      .busy(busy), .grant_id(gid), .err(err)
   );

   tx_cmd_arbiter #(
      .NUM_CH(2), .FRAME_LEN(3), .RR_EN(1),
      .IDLE_BYTE(8'h00), .TIMEOUT_CYC(16'd16)
   ) dut_rr (
      .clock(clock), .reset(reset), .ch_req(r_req), .ch_frame(r_frame),
      .ch_mask(r_mask), .ch_ack(r_ack), .tx_bits(r_bits), .tx_done(r_done),
      .busy(r_busy), .grant_id(r_gid), .err(r_err)
   );

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  mask;
      logic [23:0] f0;
      logic [23:0] f1;
      logic        hit;
      logic [2:0]  gnt;
      logic        scr;
   } vec_t;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];
   logic [2:0] prev_gid = 3'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_pop(input string nm, input logic [7:0] act);
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got %0h want <empty scoreboard>", nm, act);
      end else begin
         chk(nm, act, exp_q.pop_front());
      end
   endtask

   task automatic push_frame(input logic [23:0] f);
      for (int b = 0; b < 3; b++)
         exp_q.push_back(f[b*8 +: 8]);
   endtask

   // Sends three bytes with tx_done roughly every 10 cycles; ends on the DONE cycle.
   task automatic send_frame();
      for (int b = 0; b < 3; b++) begin
         repeat (9) @(negedge clock);
         chk_pop($sformatf("byte%0d", b), bits);
         chk("busy_mid", busy, 1);
         done = 1'b1;
         @(negedge clock);
         done = 1'b0;
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      @(negedge clock);
      req   = v.req;
      mask  = v.mask;
      frame = {v.f1, v.f0};
      if (v.hit)
         push_frame(v.gnt == 3'd1 ? v.f1 : v.f0);
      @(negedge clock);
      if (!v.hit) begin
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("v%0d_nobusy", n), busy, 0);
            chk($sformatf("v%0d_idlebits", n), bits, 8'h00);
            chk($sformatf("v%0d_noack", n), ack, 0);
            chk($sformatf("v%0d_gidhold", n), gid, prev_gid);
            @(negedge clock);
         end
         req = 2'b00;
         return;
      end
      chk($sformatf("v%0d_busy", n), busy, 1);
      chk($sformatf("v%0d_gid", n), gid, v.gnt);
      prev_gid = v.gnt;
      if (v.scr) begin
         frame = 48'hFFFF_FFFF_FFFF;
         mask  = 2'b00;
      end
      req = 2'b00;
      send_frame();
      chk($sformatf("v%0d_ack", n), ack, 32'(1) << v.gnt);
      chk($sformatf("v%0d_donebits", n), bits, 8'h00);
      chk($sformatf("v%0d_err", n), err, 0);
      @(negedge clock);
      chk($sformatf("v%0d_ackclr", n), ack, 0);
      chk($sformatf("v%0d_idle", n), busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[9];
      int   wait_n;
      logic [23:0] rf [2];

      vt[0] = '{2'b01, 2'b11, 24'h030201, 24'h0C0B0A, 1'b1, 3'd0, 1'b0};
      vt[1] = '{2'b10, 2'b11, 24'h030201, 24'h0C0B0A, 1'b1, 3'd1, 1'b0};
      vt[2] = '{2'b11, 2'b11, 24'h030201, 24'h0C0B0A, 1'b1, 3'd0, 1'b0};
      vt[3] = '{2'b11, 2'b10, 24'h030201, 24'h0C0B0A, 1'b1, 3'd1, 1'b0};
      vt[4] = '{2'b01, 2'b10, 24'h030201, 24'h0C0B0A, 1'b0, 3'd0, 1'b0};
      vt[5] = '{2'b00, 2'b11, 24'h030201, 24'h0C0B0A, 1'b0, 3'd0, 1'b0};
      vt[6] = '{2'b11, 2'b11, 24'h030201, 24'h0C0B0A, 1'b1, 3'd0, 1'b1};
      vt[7] = '{2'b10, 2'b01, 24'h030201, 24'h0C0B0A, 1'b0, 3'd0, 1'b0};
      vt[8] = '{2'b11, 2'b01, 24'h112233, 24'h0C0B0A, 1'b1, 3'd0, 1'b0};

      req = 2'b01; mask = 2'b11; frame = {24'h0C0B0A, 24'h030201}; done = 1'b0;
      r_req = 2'b00; r_mask = 2'b11; r_frame = {24'h0C0B0A, 24'h030201}; r_done = 1'b0;

      // Reset state, with a request already pending.
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_bits", bits, 8'h00);
      chk("rst_gid", gid, 0);
      chk("rst_err", err, 0);
      chk("rst_rr_busy", r_busy, 0);
      push_frame(24'h030201);
      reset = 1'b1;
      @(negedge clock);
      chk("first_grant_busy", busy, 1);
      chk("first_grant_bits", bits, 8'h01);
      req = 2'b00;
      send_frame();
      chk("first_ack", ack, 2'b01);
      @(negedge clock);

      // tx_done while idle must not start or advance anything.
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
      chk("idle_done_busy", busy, 0);
      chk("idle_done_bits", bits, 8'h00);

      for (int i = 0; i < 9; i++)
         run_vec(i, vt[i]);

      // Both channels held: 0 first, ack, then 1 after one idle cycle.
      @(negedge clock);
      req = 2'b11; mask = 2'b11; frame = {24'h0C0B0A, 24'h030201};
      push_frame(24'h030201);
      @(negedge clock);
      chk("fp_gid0", gid, 0);
      send_frame();
      chk("fp_ack0", ack, 2'b01);
      chk("fp_busy_done", busy, 1);
      req = 2'b10;
      push_frame(24'h0C0B0A);
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
      chk("fp_gap_busy", busy, 0);
      chk("fp_gap_ack", ack, 0);
      @(negedge clock);
      chk("fp_gid1", gid, 1);
      chk("fp_busy1", busy, 1);
      send_frame();
      chk("fp_ack1", ack, 2'b10);
      req = 2'b00;
      @(negedge clock);
      chk("fp_idle", busy, 0);

      // Reset mid-frame, coinciding with a tx_done.
      @(negedge clock);
      req = 2'b01; frame = {24'h0C0B0A, 24'h030201};
      push_frame(24'h030201);
      @(negedge clock);
      for (int b = 0; b < 2; b++) begin
         repeat (9) @(negedge clock);
         chk_pop($sformatf("rst_byte%0d", b), bits);
         done = 1'b1;
         @(negedge clock);
         done = 1'b0;
      end
      repeat (4) @(negedge clock);
      reset = 1'b0;
      done  = 1'b1;
      @(negedge clock);
      done  = 1'b0;
      reset = 1'b1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_bits", bits, 8'h00);
      exp_q.delete();
      push_frame(24'h030201);
      @(negedge clock);
      chk("regrant_busy", busy, 1);
      chk("regrant_gid", gid, 0);
      chk("regrant_ack", ack, 0);
      req = 2'b00;
      send_frame();
      chk("regrant_ack_done", ack, 2'b01);
      @(negedge clock);

      // Round-robin instance: both held for four frames.
      rf[0] = 24'h030201;
      rf[1] = 24'h0C0B0A;
      @(negedge clock);
      r_req = 2'b11;
      for (int f = 0; f < 4; f++) begin
         wait_n = 0;
         @(negedge clock);
         while (!r_busy && wait_n < 20) begin
            @(negedge clock);
            wait_n++;
         end
         chk($sformatf("rr_wait%0d", f), r_busy, 1);
         chk($sformatf("rr_gid%0d", f), r_gid, f % 2);
         push_frame(rf[f % 2]);
         for (int b = 0; b < 3; b++) begin
            chk_pop($sformatf("rr_f%0d_b%0d", f, b), r_bits);
            r_done = 1'b1;
            @(negedge clock);
            r_done = 1'b0;
            if (b < 2) @(negedge clock);
         end
         chk($sformatf("rr_ack%0d", f), r_ack, 32'(1) << (f % 2));
      end
      r_req = 2'b00;
      @(negedge clock);

`ifdef TX_ARB_TIMEOUT_EN
      // Withheld tx_done: err one cycle, 16 cycles after SEND entry.
      @(negedge clock);
      req = 2'b01; mask = 2'b11;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         chk($sformatf("wd_quiet%0d", k), err, 0);
      end
      @(negedge clock);
      chk("wd_err", err, 1);
      chk("wd_noack", ack, 0);
      @(negedge clock);
      chk("wd_err_clr", err, 0);
      chk("wd_idle", busy, 0);
      push_frame(24'h030201);
      @(negedge clock);
      chk("wd_regrant", busy, 1);
      chk("wd_regrant_gid", gid, 0);
      req = 2'b00;
      send_frame();
      chk("wd_ack", ack, 2'b01);
      @(negedge clock);
`endif

      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
